// File: rtl/booth_multiplier.sv
// Iterative radix-2 Booth signed multiplier: WIDTH add/sub+shift iterations, truncated
// WIDTH-bit product, overflow flag and a one-cycle ready pulse.
module booth_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             ctrl_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [WIDTH:0]      m_reg;
  logic [2*WIDTH+1:0]  p;
  logic [WIDTH:0]      h_cur, h_sum;
  logic [2*WIDTH+1:0]  p_shift;
  logic [WIDTH:0]      fp_hi;
  logic                last_iter;
  logic                ovf;

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // P = {H (WIDTH+1), Q (WIDTH), q_1}; H is one bit wider than the operands so
  // subtracting the most negative multiplicand cannot wrap.
  always_comb begin
    h_cur = p[2*WIDTH+1:WIDTH+1];
    h_sum = h_cur;
    unique case (p[1:0])
      2'b01:   h_sum = h_cur + m_reg;
      2'b10:   h_sum = h_cur - m_reg;
      default: h_sum = h_cur;
    endcase
    p_shift = {h_sum[WIDTH], h_sum, p[WIDTH:1]};
    // Full product is p_shift[2W:1]; it fits iff its top W+1 bits are all equal.
    fp_hi   = p_shift[2*WIDTH:WIDTH];
    ovf     = !((fp_hi == '0) || (fp_hi == '1));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next     = state;
    data_resultRDY = 1'b0;
    ctrl_busy      = 1'b0;
    unique case (state)
      IDLE: if (ctrl_MULT) state_next = RUN;
      RUN: begin
        ctrl_busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        data_resultRDY = 1'b1;
        state_next     = ctrl_MULT ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt            <= '0;
      m_reg          <= '0;
      p              <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (ctrl_MULT) begin
            m_reg <= {data_operandA[WIDTH-1], data_operandA};
            p     <= {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
            cnt   <= '0;
          end
        end
        RUN: begin
          p   <= p_shift;
          cnt <= cnt + CNT_W'(1);
          if (last_iter) begin
            data_result    <= p_shift[WIDTH:1];
            data_exception <= ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed scenarios plus randomized operands
// checked against a plain 64-bit signed multiply.
module tb_booth_multiplier;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b1;
  logic         ctrl_MULT = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         ctrl_busy;

  int errors = 0;
  int checks = 0;

  booth_multiplier #(.WIDTH(W), .CNT_W(6)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .ctrl_busy      (ctrl_busy)
  );

  always #5 clock = ~clock;

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic e);
    longint prod;
    prod = longint'($signed(a)) * longint'($signed(b));
    r = prod[W-1:0];
    e = (prod != longint'($signed(r)));
  endfunction

  // Called at a negedge; start edge is the next posedge. Optional restart pulse at cycle restart_at.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int restart_at, input string name);
    logic [W-1:0] er, got_r;
    logic         ee, got_e;
    int           rdy_k, busy_n, pulses;
    model(a, b, er, ee);
    got_r = 'x; got_e = 1'bx;
    ctrl_MULT = 1'b1; data_operandA = a; data_operandB = b;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; data_operandA = $urandom; data_operandB = $urandom;
    rdy_k = -1; busy_n = 0; pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        pulses++;
        if (rdy_k < 0) begin rdy_k = k; got_r = data_result; got_e = data_exception; end
      end
      if (ctrl_busy) busy_n++;
      if (k == restart_at) begin
        ctrl_MULT = 1'b1; data_operandA = 100; data_operandB = 100;
      end else if (k == restart_at + 1) begin
        ctrl_MULT = 1'b0;
      end
    end
    checks++; if (rdy_k !== 32) begin errors++; $display("FAIL %s latency got=%0d exp=32", name, rdy_k); end
    checks++; if (busy_n !== 32) begin errors++; $display("FAIL %s busy_cycles got=%0d exp=32", name, busy_n); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL %s rdy_pulses got=%0d exp=1", name, pulses); end
    checks++; if (got_r !== er) begin errors++; $display("FAIL %s result got=%h exp=%h (a=%h b=%h)", name, got_r, er, a, b); end
    checks++; if (got_e !== ee) begin errors++; $display("FAIL %s exception got=%b exp=%b (a=%h b=%h)", name, got_e, ee, a, b); end
    checks++; if (data_result !== er) begin errors++; $display("FAIL %s result_hold got=%h exp=%h", name, data_result, er); end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({data_result, data_exception, data_resultRDY, ctrl_busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h/%b/%b/%b exp=0", data_result, data_exception, data_resultRDY, ctrl_busy);
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({data_resultRDY, ctrl_busy} !== 2'b00) begin
      errors++; $display("FAIL reset_idle got rdy=%b busy=%b exp=0/0", data_resultRDY, ctrl_busy);
    end
  endtask

  task automatic test_basic();
    do_op(32'd7, -32'sd3, -1, "basic_7x-3");
  endtask

  task automatic test_corners();
    do_op(32'h8000_0000, 32'hFFFF_FFFF, -1, "minneg_x_-1");
    do_op(32'h8000_0000, 32'd1,         -1, "minneg_x_1");
    do_op(32'd65536,     32'd65536,     -1, "2p16_sq");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "neg1_sq");
    do_op(32'h7FFF_FFFF, 32'h8000_0000, -1, "maxpos_x_minneg");
  endtask

  task automatic test_ignore_start();
    do_op(32'd5, 32'd6, 10, "ignore_start");
  endtask

  task automatic test_async_reset();
    int bad;
    ctrl_MULT = 1'b1; data_operandA = 9; data_operandB = 9;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    repeat (12) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (data_result !== '0) begin errors++; $display("FAIL areset_result got=%h exp=0", data_result); end
    checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL areset_exception got=%b exp=0", data_exception); end
    checks++; if ({data_resultRDY, ctrl_busy} !== 2'b00) begin
      errors++; $display("FAIL areset_flags got rdy=%b busy=%b exp=0/0", data_resultRDY, ctrl_busy);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (data_resultRDY || ctrl_busy) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL aborted_op_activity got=%0d exp=0", bad); end
    do_op(-32'sd4, 32'd8, -1, "after_reset_-4x8");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r1, r2, got1, got2;
    logic         e1, e2;
    int           k1, k2, pulses, busy_n, bad;
    model(32'd3, 32'd4, r1, e1);
    model(-32'sd2, -32'sd2, r2, e2);
    got1 = 'x; got2 = 'x; k1 = -1; k2 = -1; pulses = 0; busy_n = 0; bad = 0;
    ctrl_MULT = 1'b1; data_operandA = 3; data_operandB = 4;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        pulses++;
        if (k1 < 0) begin k1 = k; got1 = data_result; end
        else if (k2 < 0) begin k2 = k; got2 = data_result; end
      end
      if (ctrl_busy) busy_n++;
      if (k <= 65 && ctrl_busy === data_resultRDY) bad++;
      if (k == 32) begin
        ctrl_MULT = 1'b1; data_operandA = -32'sd2; data_operandB = -32'sd2;
      end else if (k == 33) begin
        ctrl_MULT = 1'b0;
      end
    end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
    checks++; if (k1 !== 32) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=32", k1); end
    checks++; if (k2 !== 65) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=65", k2); end
    checks++; if (got1 !== r1) begin errors++; $display("FAIL b2b_first_result got=%h exp=%h", got1, r1); end
    checks++; if (got2 !== r2) begin errors++; $display("FAIL b2b_second_result got=%h exp=%h", got2, r2); end
    checks++; if (busy_n !== 64) begin errors++; $display("FAIL b2b_busy_cycles got=%0d exp=64", busy_n); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_busy_vs_rdy got=%0d exp=0", bad); end
  endtask

  task automatic test_random();
    logic [W-1:0] edge_vals [6];
    logic [W-1:0] a, b;
    edge_vals[0] = 32'h8000_0000; edge_vals[1] = 32'h7FFF_FFFF; edge_vals[2] = 32'h0;
    edge_vals[3] = 32'h1;         edge_vals[4] = 32'hFFFF_FFFF; edge_vals[5] = 32'h0001_0000;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = W'($signed($urandom_range(0, 2000)) - 1000);
                 b = W'($signed($urandom_range(0, 2000)) - 1000); end
        2: begin a = edge_vals[$urandom_range(0, 5)]; b = edge_vals[$urandom_range(0, 5)]; end
        default: begin a = $urandom & 32'h8000_FFFF; b = $urandom | 32'h0000_8000; end
      endcase
      do_op(a, b, -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
